// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI-Lite master port among NUM_SLV requesters, independent read/write paths.
// Define AXI_LITE_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module axi_lite_arbiter #(
  parameter int NUM_SLV = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int IDXW = $clog2(NUM_SLV)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_SLV-1:0]              slv_aw_valid_i,
  output logic [NUM_SLV-1:0]              slv_aw_ready_o,
  input  logic [NUM_SLV-1:0][AW-1:0]      slv_aw_addr_i,
  input  logic [NUM_SLV-1:0][2:0]         slv_aw_prot_i,
  input  logic [NUM_SLV-1:0]              slv_w_valid_i,
  output logic [NUM_SLV-1:0]              slv_w_ready_o,
  input  logic [NUM_SLV-1:0][DW-1:0]      slv_w_data_i,
  input  logic [NUM_SLV-1:0][DW/8-1:0]    slv_w_strb_i,
  output logic [NUM_SLV-1:0]              slv_b_valid_o,
  input  logic [NUM_SLV-1:0]              slv_b_ready_i,
  output logic [NUM_SLV-1:0][1:0]         slv_b_resp_o,
  input  logic [NUM_SLV-1:0]              slv_ar_valid_i,
  output logic [NUM_SLV-1:0]              slv_ar_ready_o,
  input  logic [NUM_SLV-1:0][AW-1:0]      slv_ar_addr_i,
  input  logic [NUM_SLV-1:0][2:0]         slv_ar_prot_i,
  output logic [NUM_SLV-1:0]              slv_r_valid_o,
  input  logic [NUM_SLV-1:0]              slv_r_ready_i,
  output logic [NUM_SLV-1:0][DW-1:0]      slv_r_data_o,
  output logic [NUM_SLV-1:0][1:0]         slv_r_resp_o,
  output logic                            mst_aw_valid_o,
  input  logic                            mst_aw_ready_i,
  output logic [AW-1:0]                   mst_aw_addr_o,
  output logic [2:0]                      mst_aw_prot_o,
  output logic                            mst_w_valid_o,
  input  logic                            mst_w_ready_i,
  output logic [DW-1:0]                   mst_w_data_o,
  output logic [DW/8-1:0]                 mst_w_strb_o,
  input  logic                            mst_b_valid_i,
  output logic                            mst_b_ready_o,
  input  logic [1:0]                      mst_b_resp_i,
  output logic                            mst_ar_valid_o,
  input  logic                            mst_ar_ready_i,
  output logic [AW-1:0]                   mst_ar_addr_o,
  output logic [2:0]                      mst_ar_prot_o,
  input  logic                            mst_r_valid_i,
  output logic                            mst_r_ready_o,
  input  logic [DW-1:0]                   mst_r_data_i,
  input  logic [1:0]                      mst_r_resp_i,
  output logic                            wr_busy_o,
  output logic                            rd_busy_o
);
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_e;
  w_state_e wst_q, wst_d;
  r_state_e rst_q, rst_d;
  logic [IDXW-1:0] wgnt_q, wgnt_d, rgnt_q, rgnt_d, wptr, rptr;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  function automatic logic [IDXW-1:0] pick(input logic [NUM_SLV-1:0] v, input logic [IDXW-1:0] p);
    logic [IDXW-1:0] r;
    logic f;
    int k;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      k = (int'(p) + i) % NUM_SLV;
      if (!f && v[k]) begin
        r = IDXW'(k);
        f = 1'b1;
      end
    end
    return r;
  endfunction
`ifdef AXI_LITE_ARB_RR_EN
  logic [IDXW-1:0] wptr_q, rptr_q;
  function automatic logic [IDXW-1:0] inc(input logic [IDXW-1:0] g);
    return (int'(g) == NUM_SLV - 1) ? '0 : g + 1'b1;
  endfunction
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= (mst_b_valid_i & mst_b_ready_o) ? inc(wgnt_q) : wptr_q;
      rptr_q <= (mst_r_valid_i & mst_r_ready_o) ? inc(rgnt_q) : rptr_q;
    end
  assign wptr = wptr_q;
  assign rptr = rptr_q;
`else
  assign wptr = '0;
  assign rptr = '0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      wgnt_q    <= '0;
      rgnt_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      wgnt_q    <= wgnt_d;
      rgnt_q    <= rgnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  always_comb begin
    wst_d          = wst_q;
    wgnt_d         = wgnt_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    slv_aw_ready_o = '0;
    slv_w_ready_o  = '0;
    slv_b_valid_o  = '0;
    slv_b_resp_o   = '0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    mst_aw_addr_o  = slv_aw_addr_i[wgnt_q];
    mst_aw_prot_o  = slv_aw_prot_i[wgnt_q];
    mst_w_data_o   = slv_w_data_i[wgnt_q];
    mst_w_strb_o   = slv_w_strb_i[wgnt_q];
    case (wst_q)
      W_IDLE: if (|slv_aw_valid_i) begin
        wgnt_d = pick(slv_aw_valid_i, wptr);
        wst_d  = W_REQ;
      end
      W_REQ: begin
        // a channel that already handshook stays quiet until the other catches up
        mst_aw_valid_o         = slv_aw_valid_i[wgnt_q] & ~aw_done_q;
        mst_w_valid_o          = slv_w_valid_i[wgnt_q] & ~w_done_q;
        slv_aw_ready_o[wgnt_q] = mst_aw_ready_i & ~aw_done_q;
        slv_w_ready_o[wgnt_q]  = mst_w_ready_i & ~w_done_q;
        aw_done_d              = aw_done_q | (mst_aw_valid_o & mst_aw_ready_i);
        w_done_d               = w_done_q | (mst_w_valid_o & mst_w_ready_i);
        if (aw_done_d && w_done_d) wst_d = W_RESP;
      end
      W_RESP: begin
        mst_b_ready_o         = slv_b_ready_i[wgnt_q];
        slv_b_valid_o[wgnt_q] = mst_b_valid_i;
        slv_b_resp_o[wgnt_q]  = mst_b_resp_i;
        if (mst_b_valid_i && mst_b_ready_o) begin
          wst_d     = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end
  always_comb begin
    rst_d          = rst_q;
    rgnt_d         = rgnt_q;
    slv_ar_ready_o = '0;
    slv_r_valid_o  = '0;
    slv_r_data_o   = '0;
    slv_r_resp_o   = '0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    mst_ar_addr_o  = slv_ar_addr_i[rgnt_q];
    mst_ar_prot_o  = slv_ar_prot_i[rgnt_q];
    case (rst_q)
      R_IDLE: if (|slv_ar_valid_i) begin
        rgnt_d = pick(slv_ar_valid_i, rptr);
        rst_d  = R_REQ;
      end
      R_REQ: begin
        mst_ar_valid_o         = slv_ar_valid_i[rgnt_q];
        slv_ar_ready_o[rgnt_q] = mst_ar_ready_i;
        if (mst_ar_valid_o && mst_ar_ready_i) rst_d = R_RESP;
      end
      R_RESP: begin
        mst_r_ready_o         = slv_r_ready_i[rgnt_q];
        slv_r_valid_o[rgnt_q] = mst_r_valid_i;
        slv_r_data_o[rgnt_q]  = mst_r_data_i;
        slv_r_resp_o[rgnt_q]  = mst_r_resp_i;
        if (mst_r_valid_i && mst_r_ready_o) rst_d = R_IDLE;
      end
      default: rst_d = R_IDLE;
    endcase
  end
  assign wr_busy_o = wst_q != W_IDLE;
  assign rd_busy_o = rst_q != R_IDLE;
endmodule
